alu_share_arbiter: RTL

Sequencer and arbiter that shares the single execute-stage ALU between two requesters: port 0 is the pipeline execute stage and port 1 is the auxiliary/co-processor path. The block accepts one operation at a time over a valid/ready handshake, drives the ALU control code and operands, and holds them for the required number of cycles: one for simple ops, `MULT_CYCLES` for multiply. It then returns the captured result to the requester that issued the operation. It sits between the requesters and the ALU, and replaces the direct ALU-control-to-ALU connection when sharing is required.

---
 rtl/alu_share_arbiter_if.sv | 62 ++++++
 rtl/alu_share_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : alu_share_arbiter_if
// Purpose  : Bundles the two requester ports and the ALU-side signals of
//            alu_share_arbiter into one interface.
//            slave  - the arbiter's view (drives ready/rvalid/rdata and the
//                     ALU control/operands, receives requests and the result)
//            master - the requesters'/ALU's view (the opposite directions)
// Signals  : rX_valid, rX_ready, rX_op[2:0], rX_a, rX_b,
//            rX_rvalid, rX_rdata          (X = 0 execute stage, 1 co-processor)
//            alu_ctrl[2:0], alu_a, alu_b, alu_result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    // Port 0: pipeline execute stage
    logic             r0_valid;
    logic             r0_ready;
    logic [2:0]       r0_op;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;
    logic             r0_rvalid;
    logic [WIDTH-1:0] r0_rdata;

    // Port 1: auxiliary / co-processor path
    logic             r1_valid;
    logic             r1_ready;
    logic [2:0]       r1_op;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;
    logic             r1_rvalid;
    logic [WIDTH-1:0] r1_rdata;

    // Shared ALU
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        output r0_ready, r0_rvalid, r0_rdata,
        input  r1_valid, r1_op, r1_a, r1_b,
        output r1_ready, r1_rvalid, r1_rdata,
        output alu_ctrl, alu_a, alu_b,
        input  alu_result
    );

    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        input  r0_ready, r0_rvalid, r0_rdata,
        output r1_valid, r1_op, r1_a, r1_b,
        input  r1_ready, r1_rvalid, r1_rdata,
        input  alu_ctrl, alu_a, alu_b,
        output alu_result
    );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : alu_share_arbiter
// Purpose  : Shares the single execute-stage ALU between the pipeline
//            (port 0) and the co-processor path (port 1). One operation is
//            accepted at a time over valid/ready, its control code and
//            operands are held on the ALU for one cycle (or MULT_CYCLES for
//            multiply), and the ALU result is returned to the issuing port
//            as a one-cycle rvalid strobe with rdata held afterwards.
// Ports    : clk            - clock, rising edge
//            rst            - synchronous reset, active high
//            bus (slave)    - requester ports r0_*/r1_* and ALU signals
//                             alu_ctrl/alu_a/alu_b/alu_result
// Params   : WIDTH          - operand/result width (default 32)
//            MULT_CYCLES    - ALU multiply latency in cycles, >= 1 (default 3)
// Macro    : ALU_ARB_FIXED_PRIO_EN - when defined, port 0 always wins a
//            contended grant and no round-robin pointer is built; port 1 may
//            starve. When undefined, contended grants alternate round-robin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module alu_share_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);

    // Counter only needs to reach MULT_CYCLES-1; keep at least one bit so
    // MULT_CYCLES=1 still elaborates.
    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_mul = 3'b110;
    localparam logic [2:0] c_op_rsv = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;      // 0 = port 0, 1 = port 1
    logic             r_rsv;        // in-flight op is the reserved code
    logic [2:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_rvalid0;
    logic             r_rvalid1;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;

    //--------------------------------------------------------------------------
    // Grant selection
    //--------------------------------------------------------------------------
    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_hs;
    logic [2:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // Gating with rst keeps ready low while the block is held in reset.
    assign w_idle = (r_state == ST_IDLE) && !rst;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Port 0 always wins; port 1 only gets the ALU when port 0 is quiet.
    assign w_grant0 = w_idle && bus.r0_valid;
    assign w_grant1 = w_idle && bus.r1_valid && !bus.r0_valid;
`else
    // Round-robin pointer: names the port that wins the next contended grant.
    logic r_rr;

    assign w_grant0 = w_idle && bus.r0_valid && (!bus.r1_valid || !r_rr);
    assign w_grant1 = w_idle && bus.r1_valid && (!bus.r0_valid ||  r_rr);

    // After any grant, point at the port that was not served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_grant0) begin
            r_rr <= 1'b1;
        end else if (w_grant1) begin
            r_rr <= 1'b0;
        end
    end
`endif

    // A grant is only ever issued to a valid port, so grant == handshake.
    assign w_hs     = w_grant0 || w_grant1;
    assign w_sel_op = w_grant1 ? bus.r1_op : bus.r0_op;
    assign w_sel_a  = w_grant1 ? bus.r1_a  : bus.r0_a;
    assign w_sel_b  = w_grant1 ? bus.r1_b  : bus.r0_b;

    //--------------------------------------------------------------------------
    // Sequencer
    //--------------------------------------------------------------------------
    // The ALU-facing registers are loaded directly at the handshake and
    // cleared on the way back to IDLE, so the ALU sees zeros in IDLE and a
    // stable code/operand set for every BUSY cycle without extra muxing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_rsv      <= 1'b0;
            r_alu_ctrl <= c_op_add;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            // Result strobes are single-cycle pulses.
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_owner    <= w_grant1;
                        r_rsv      <= (w_sel_op == c_op_rsv);
                        // The reserved code must never reach the ALU.
                        r_alu_ctrl <= (w_sel_op == c_op_rsv) ? c_op_add : w_sel_op;
                        r_alu_a    <= w_sel_a;
                        r_alu_b    <= w_sel_b;
                        r_cnt      <= (w_sel_op == c_op_mul) ? c_mul_load : '0;
                        r_state    <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        if (r_owner) begin
                            r_rdata1  <= r_rsv ? '0 : bus.alu_result;
                            r_rvalid1 <= 1'b1;
                        end else begin
                            r_rdata0  <= r_rsv ? '0 : bus.alu_result;
                            r_rvalid0 <= 1'b1;
                        end
                        r_alu_ctrl <= c_op_add;
                        r_alu_a    <= '0;
                        r_alu_b    <= '0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.r0_ready  = w_grant0;
    assign bus.r1_ready  = w_grant1;
    assign bus.r0_rvalid = r_rvalid0;
    assign bus.r1_rvalid = r_rvalid1;
    assign bus.r0_rdata  = r_rdata0;
    assign bus.r1_rdata  = r_rdata1;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;

endmodule

`default_nettype wire
